// File: rtl/mmio_fabric.sv
// mmio_fabric: table-driven MMIO interconnect between the CPU data port and
// up to 16 peripheral slaves.
//
// Each access is routed by looking up the top address nibble in REGION_MAP.
// The fabric produces a one-hot slave select, per-slave gated byte enables,
// and read wait states that stall the CPU. Accesses to unmapped regions are
// reported as errors.
//
// Optional build macro: MMIO_FABRIC_ERRCNT_EN
//   Defined:   err_count is a saturating count of unmapped accesses.
//   Undefined: err_count is tied to zero and no counter is built.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | accepting requests; writes and zero-latency reads finish here
// ST_WAIT | wait-state read in progress; counter counts down to zero
// ST_RESP | captured read data is presented and the stall is released

module mmio_fabric #(
    parameter int          NUM_SLAVES = 9,
    parameter logic [63:0] REGION_MAP = 64'hFFFF_8877_6543_2100,
    parameter logic [31:0] SLAVE_LAT  = 32'h0,
    parameter int          ERRCNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cpu_req,
    input  logic [31:0]             cpu_addr,
    input  logic [31:0]             cpu_wdata,
    input  logic [3:0]              cpu_wenable,
    output logic [31:0]             cpu_rdata,
    output logic                    cpu_stall,
    output logic                    cpu_err,
    output logic [NUM_SLAVES-1:0]   slv_sel,
    output logic [31:0]             slv_addr,
    output logic [31:0]             slv_wdata,
    output logic [4*NUM_SLAVES-1:0] slv_wenable,
    input  logic [32*NUM_SLAVES-1:0] slv_rdata,
    output logic [ERRCNT_W-1:0]     err_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  cnt_q;
    logic [31:0] rdata_q;

    logic [3:0]  idx;
    logic [1:0]  lat;
    logic        mapped;
    logic        is_read;
    logic        new_access;
    logic        start_wait;
    logic [31:0] sel_rdata;

    assign slv_addr  = cpu_addr;
    assign slv_wdata = cpu_wdata;

    // Region lookup and per-slave latency for the current address
    always_comb begin
        idx        = REGION_MAP[{cpu_addr[31:28], 2'b00} +: 4];
        lat        = SLAVE_LAT[{idx, 1'b0} +: 2];
        mapped     = ({1'b0, idx} < 5'(NUM_SLAVES));
        is_read    = (cpu_wenable == 4'b0000);
        // A request seen in WAIT or RESP belongs to the read already underway
        new_access = cpu_req && (state_q == ST_IDLE);
        start_wait = new_access && mapped && is_read && (lat != 2'd0);
    end

    // One-hot select, gated byte enables and read-data mux over the slaves
    always_comb begin
        slv_sel     = '0;
        slv_wenable = '0;
        sel_rdata   = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (cpu_req && mapped && (idx == 4'(i))) begin
                slv_sel[i]           = 1'b1;
                slv_wenable[4*i +: 4] = cpu_wenable;
                sel_rdata            = slv_rdata[32*i +: 32];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_wait) state_d = ST_WAIT;
            ST_WAIT: if (cnt_q == 2'd0) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Wait-state down-counter and read-data capture at terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 2'd0;
            rdata_q <= 32'h0;
        end else begin
            if (start_wait) begin
                cnt_q <= lat - 2'd1;
            end else if (state_q == ST_WAIT && cnt_q != 2'd0) begin
                cnt_q <= cnt_q - 2'd1;
            end
            if (state_q == ST_WAIT && cnt_q == 2'd0) begin
                rdata_q <= sel_rdata;
            end
        end
    end

    // CPU-facing outputs: stall, error pulse and read-data steering
    always_comb begin
        cpu_stall = 1'b0;
        cpu_err   = 1'b0;
        cpu_rdata = 32'h0;
        case (state_q)
            ST_IDLE: begin
                cpu_stall = start_wait;
                cpu_err   = new_access && !mapped;
                if (new_access && mapped && is_read && lat == 2'd0) begin
                    cpu_rdata = sel_rdata;
                end
            end
            ST_WAIT: cpu_stall = 1'b1;
            ST_RESP: cpu_rdata = rdata_q;
            default: cpu_stall = 1'b0;
        endcase
    end

`ifdef MMIO_FABRIC_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_cnt_q;

    // Saturating count of unmapped accesses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (cpu_err && (err_cnt_q != {ERRCNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + ERRCNT_W'(1);
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_mmio_fabric.sv
// Directed bench for mmio_fabric: default region map, slave 1 latency 3,
// slave 2 latency 1, slave 3 latency 2, all other slaves latency 0.
module tb_mmio_fabric;

    localparam int NS = 9;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cpu_req = 1'b0;
    logic [31:0]     cpu_addr = '0;
    logic [31:0]     cpu_wdata = '0;
    logic [3:0]      cpu_wenable = '0;
    logic [31:0]     cpu_rdata;
    logic            cpu_stall;
    logic            cpu_err;
    logic [NS-1:0]   slv_sel;
    logic [31:0]     slv_addr;
    logic [31:0]     slv_wdata;
    logic [4*NS-1:0] slv_wenable;
    logic [32*NS-1:0] slv_rdata = '0;
    logic [7:0]      err_count;

    int checks = 0;
    int errors = 0;

    mmio_fabric #(
        .NUM_SLAVES(NS),
        .REGION_MAP(64'hFFFF_8877_6543_2100),
        .SLAVE_LAT (32'h0000_009C),
        .ERRCNT_W  (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_wenable(cpu_wenable),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .cpu_err    (cpu_err),
        .slv_sel    (slv_sel),
        .slv_addr   (slv_addr),
        .slv_wdata  (slv_wdata),
        .slv_wenable(slv_wenable),
        .slv_rdata  (slv_rdata),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic set_slv(input int i, input logic [31:0] d);
        slv_rdata[32*i +: 32] = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", cpu_stall); end
        checks++; if (cpu_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", cpu_err); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", cpu_rdata); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_errcnt got %0d want 0", err_count); end
        checks++; if (slv_sel !== '0) begin errors++; $display("FAIL reset_sel got %b want 0", slv_sel); end
        rst_n = 1'b1;
    endtask

    task automatic test_write();
        // region 4 -> slave 3 (latency 2, but writes never stall)
        next_cycle();
        cpu_req = 1'b1; cpu_addr = 32'h4000_0010; cpu_wdata = 32'hCAFE_F00D; cpu_wenable = 4'b0011;
        @(negedge clk);
        checks++; if (slv_sel !== 9'b0_0000_1000) begin errors++; $display("FAIL wr4_sel got %b want 000001000", slv_sel); end
        checks++; if (slv_wenable !== 36'h0_0000_3000) begin errors++; $display("FAIL wr4_wen got %h want 000003000", slv_wenable); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL wr4_stall got %b want 0", cpu_stall); end
        checks++; if (slv_addr !== 32'h4000_0010 || slv_wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL wr4_bcast got %h/%h want 40000010/cafef00d", slv_addr, slv_wdata); end
        // region 5 -> slave 4
        next_cycle();
        cpu_addr = 32'h5000_0000; cpu_wenable = 4'b1100;
        @(negedge clk);
        checks++; if (slv_sel !== 9'b0_0001_0000) begin errors++; $display("FAIL wr5_sel got %b want 000010000", slv_sel); end
        checks++; if (slv_wenable !== 36'h0_000C_0000) begin errors++; $display("FAIL wr5_wen got %h want 0000c0000", slv_wenable); end
        next_cycle();
        cpu_req = 1'b0; cpu_wenable = 4'b0000;
        @(negedge clk);
        checks++; if (slv_sel !== '0 || slv_wenable !== '0) begin errors++; $display("FAIL idle_sel got %b/%h want 0/0", slv_sel, slv_wenable); end
    endtask

    task automatic test_read_l0();
        set_slv(0, 32'hDEAD_BEEF);
        set_slv(8, 32'h8888_0008);
        next_cycle();
        cpu_req = 1'b1; cpu_addr = 32'h0000_0004; cpu_wenable = 4'b0000;
        @(negedge clk);
        checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd0_data got %h want deadbeef", cpu_rdata); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rd0_stall got %b want 0", cpu_stall); end
        next_cycle();
        cpu_addr = 32'hB000_0000;
        @(negedge clk);
        checks++; if (cpu_rdata !== 32'h8888_0008 || slv_sel !== 9'b1_0000_0000) begin errors++; $display("FAIL rdB_data got %h/%b want 88880008/100000000", cpu_rdata, slv_sel); end
        next_cycle();
        cpu_req = 1'b0;
    endtask

    task automatic test_wait_read();
        set_slv(1, 32'hAAAA_5555);
        next_cycle();
        cpu_req = 1'b1; cpu_addr = 32'h2000_0040; cpu_wenable = 4'b0000;
        @(negedge clk);
        checks++; if (cpu_stall !== 1'b1 || slv_sel !== 9'b0_0000_0010) begin errors++; $display("FAIL l3_c0 got stall %b sel %b want 1/000000010", cpu_stall, slv_sel); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL l3_c0_rdata got %h want 0", cpu_rdata); end
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            if (c == 3) set_slv(1, 32'h1234_5678);
            @(negedge clk);
            checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL l3_stall_c%0d got %b want 1", c, cpu_stall); end
        end
        next_cycle();
        @(negedge clk);
        checks++; if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h1234_5678) begin errors++; $display("FAIL l3_c4 got stall %b data %h want 0/12345678", cpu_stall, cpu_rdata); end
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        checks++; if (cpu_rdata !== 32'h0 || cpu_stall !== 1'b0) begin errors++; $display("FAIL l3_after got %h/%b want 0/0", cpu_rdata, cpu_stall); end
    endtask

    task automatic test_back_to_back();
        set_slv(0, 32'h0000_00A0);
        set_slv(2, 32'h2222_0002);
        // write, zero-latency read, L=1 read, then zero-latency read right after RESP
        next_cycle();
        cpu_req = 1'b1; cpu_addr = 32'h6000_0000; cpu_wenable = 4'b1111;
        @(negedge clk);
        checks++; if (slv_sel !== 9'b0_0010_0000 || cpu_stall !== 1'b0) begin errors++; $display("FAIL b2b_wr got sel %b stall %b want 000100000/0", slv_sel, cpu_stall); end
        next_cycle();
        cpu_addr = 32'h1000_0000; cpu_wenable = 4'b0000;
        @(negedge clk);
        checks++; if (cpu_rdata !== 32'h0000_00A0 || cpu_stall !== 1'b0) begin errors++; $display("FAIL b2b_rd0 got %h/%b want 000000a0/0", cpu_rdata, cpu_stall); end
        next_cycle();
        cpu_addr = 32'h3000_0000;
        @(negedge clk);
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL b2b_l1_c0 got %b want 1", cpu_stall); end
        next_cycle();
        @(negedge clk);
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL b2b_l1_c1 got %b want 1", cpu_stall); end
        next_cycle();
        @(negedge clk);
        checks++; if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h2222_0002) begin errors++; $display("FAIL b2b_l1_c2 got %b/%h want 0/22220002", cpu_stall, cpu_rdata); end
        next_cycle();
        cpu_addr = 32'h0000_0000;
        @(negedge clk);
        checks++; if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h0000_00A0) begin errors++; $display("FAIL b2b_after_resp got %b/%h want 0/000000a0", cpu_stall, cpu_rdata); end
        next_cycle();
        cpu_req = 1'b0;
    endtask

    task automatic test_unmapped();
        int bad;
        logic [7:0] exp_cnt;
        next_cycle();
        cpu_req = 1'b1; cpu_addr = 32'hD000_0000; cpu_wenable = 4'b1111;
        @(negedge clk);
        checks++; if (cpu_err !== 1'b1 || slv_sel !== '0 || slv_wenable !== '0) begin errors++; $display("FAIL unm_wr got err %b sel %b wen %h want 1/0/0", cpu_err, slv_sel, slv_wenable); end
        next_cycle();
        cpu_req = 1'b0; cpu_wenable = 4'b0000;
        @(negedge clk);
`ifdef MMIO_FABRIC_ERRCNT_EN
        exp_cnt = 8'd1;
`else
        exp_cnt = 8'd0;
`endif
        checks++; if (err_count !== exp_cnt) begin errors++; $display("FAIL unm_cnt1 got %0d want %0d", err_count, exp_cnt); end
        checks++; if (cpu_err !== 1'b0) begin errors++; $display("FAIL unm_err_idle got %b want 0", cpu_err); end
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            next_cycle();
            cpu_req = 1'b1; cpu_addr = 32'hF000_0000;
            @(negedge clk);
            checks++;
            if (cpu_rdata !== 32'h0 || cpu_err !== 1'b1 || cpu_stall !== 1'b0 || slv_sel !== '0) begin
                errors++;
                if (bad < 4) $display("FAIL unm_rd_%0d got data %h err %b stall %b sel %b want 0/1/0/0", k, cpu_rdata, cpu_err, cpu_stall, slv_sel);
                bad++;
            end
        end
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
`ifdef MMIO_FABRIC_ERRCNT_EN
        exp_cnt = 8'd255;
`else
        exp_cnt = 8'd0;
`endif
        checks++; if (err_count !== exp_cnt) begin errors++; $display("FAIL unm_sat got %0d want %0d", err_count, exp_cnt); end
    endtask

    task automatic test_reset_mid();
        set_slv(1, 32'h0BAD_0001);
        next_cycle();
        cpu_req = 1'b1; cpu_addr = 32'h2000_0000; cpu_wenable = 4'b0000;
        next_cycle();
        @(negedge clk);
        checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got %b want 1", cpu_stall); end
        #1;
        rst_n = 1'b0; cpu_req = 1'b0;
        #1;
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_mid_async got %b want 0", cpu_stall); end
        @(negedge clk);
        checks++; if (err_count !== 8'd0 || cpu_rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_vals got %0d/%h want 0/0", err_count, cpu_rdata); end
        rst_n = 1'b1;
        set_slv(1, 32'h5A5A_A5A5);
        next_cycle();
        cpu_req = 1'b1;
        for (int c = 0; c <= 3; c++) begin
            if (c > 0) next_cycle();
            @(negedge clk);
            checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL rst_fresh_c%0d got %b want 1", c, cpu_stall); end
        end
        next_cycle();
        @(negedge clk);
        checks++; if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h5A5A_A5A5) begin errors++; $display("FAIL rst_fresh_c4 got %b/%h want 0/5a5aa5a5", cpu_stall, cpu_rdata); end
        next_cycle();
        cpu_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_l0();
        test_wait_read();
        test_back_to_back();
        test_unmapped();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
